// File: rtl/clk_phase_rst_seq_pkg.sv
// Shared types and elaboration helpers for the fast-domain phase and reset sequencer.
package clk_phase_rst_seq_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StHold     = 2'd1,
    StStagger  = 2'd2,
    StRun      = 2'd3
  } seq_state_e;

  // Width needed to index n items; never below one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_legal(input int unsigned ratio, input int unsigned sync_phase,
                                      input int unsigned rst_cycles, input int unsigned n_rst,
                                      input int unsigned stagger);
    return (ratio >= 2) && (ratio <= 16) && (sync_phase < ratio) && (rst_cycles >= 1) &&
           (n_rst >= 1) && (stagger >= 1);
  endfunction

endpackage

// File: rtl/clk_phase_rst_seq_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset for single-bit level inputs.
module clk_phase_rst_seq_sync_2ff (
  input  logic clk_4x_s,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_phase_rst_seq.sv
// Fast-clock phase counter with aligned sync/slow strobes and a lock-qualified
// reset sequencer that releases N_RST resets in index order on slow-clock boundaries.
module clk_phase_rst_seq
  import clk_phase_rst_seq_pkg::*;
#(
  parameter int unsigned RATIO      = 4,
  parameter int unsigned SYNC_PHASE = 2,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned N_RST      = 2,
  parameter int unsigned STAGGER    = 4,
  parameter int unsigned LOCK_FILT  = 8,
  localparam int unsigned PW        = width_of(RATIO)
) (
  input  logic             clk_4x_s,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             ext_rst_req,
  output logic [PW-1:0]    phase,
  output logic             sync_4x,
  output logic             slow_en,
  output logic [N_RST-1:0] rst_out,
  output logic             ready
);

  localparam int unsigned CntW  = $clog2(max_u(RST_CYCLES, STAGGER)) + 1;
  localparam int unsigned IdxW  = width_of(N_RST);
  localparam int unsigned FiltW = width_of(LOCK_FILT + 1);

  if (!params_legal(RATIO, SYNC_PHASE, RST_CYCLES, N_RST, STAGGER)) begin : gen_param_err
    $error("clk_phase_rst_seq: illegal parameter set");
  end

  logic lock_s, req_s;

  clk_phase_rst_seq_sync_2ff u_sync_lock (
    .clk_4x_s (clk_4x_s),
    .rst      (rst),
    .d_i      (pll_lock),
    .q_o      (lock_s)
  );

  clk_phase_rst_seq_sync_2ff u_sync_req (
    .clk_4x_s (clk_4x_s),
    .rst      (rst),
    .d_i      (ext_rst_req),
    .q_o      (req_s)
  );

  // Phase counter and strobes; strobes decode the next phase so they line up with it.
  logic [PW-1:0] phase_q, phase_d;
  logic          sync_q, sync_d;
  logic          slow_q, slow_d;

  always_comb begin
    phase_d = (phase_q == PW'(RATIO - 1)) ? '0 : phase_q + 1'b1;
    sync_d  = (phase_d == PW'(SYNC_PHASE));
    slow_d  = (phase_d == PW'(RATIO - 1));
  end

  // Lock filter; lock_ok also drops as soon as lock_s falls, ahead of the counter clear.
  logic [FiltW-1:0] filt_q, filt_d;
  logic             lock_ok;

  always_comb begin
    if (!lock_s) begin
      filt_d = '0;
    end else if (filt_q == FiltW'(LOCK_FILT)) begin
      filt_d = filt_q;
    end else begin
      filt_d = filt_q + 1'b1;
    end
  end

  assign lock_ok = lock_s && (filt_q == FiltW'(LOCK_FILT));

  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_RST-1:0] rst_out_q, rst_out_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    if ((state_q != StWaitLock) && (!lock_ok || req_s)) begin
      state_d   = StWaitLock;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (lock_ok && !req_s) begin
            state_d = StHold;
            cnt_d   = CntW'(RST_CYCLES - 1);
          end
        end
        StHold: begin
          if (slow_q) begin
            if (cnt_q == '0) begin
              idx_d        = '0;
              cnt_d        = CntW'(STAGGER - 1);
              rst_out_d[0] = 1'b0;
              if (N_RST == 1) begin
                state_d = StRun;
                ready_d = 1'b1;
              end else begin
                state_d = StStagger;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StStagger: begin
          if (slow_q) begin
            if (cnt_q == '0) begin
              idx_d     = idx_q + 1'b1;
              cnt_d     = CntW'(STAGGER - 1);
              rst_out_d = rst_out_q & ~(N_RST'(1) << idx_d);
              if (idx_d == IdxW'(N_RST - 1)) begin
                state_d = StRun;
                ready_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StRun: begin
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      phase_q   <= '0;
      sync_q    <= 1'b0;
      slow_q    <= 1'b0;
      filt_q    <= '0;
      state_q   <= StWaitLock;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      sync_q    <= sync_d;
      slow_q    <= slow_d;
      filt_q    <= filt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign phase   = phase_q;
  assign sync_4x = sync_q;
  assign slow_en = slow_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_clk_phase_rst_seq.sv
// Bench for clk_phase_rst_seq: default instance plus a RATIO=3 / N_RST=3 instance sharing stimulus.
module tb_clk_phase_rst_seq;

  localparam int RA = 4, SPA = 2, RCA = 16, NA = 2, STA = 4;
  localparam int RB = 3, SPB = 0, RCB = 2,  NB = 3, STB = 1;

  logic clk_4x_s = 1'b0;
  logic rst = 1'b1, pll_lock = 1'b0, ext_rst_req = 1'b0;

  logic [1:0]    phase_a, phase_b;
  logic          sync_a, slow_a, ready_a, sync_b, slow_b, ready_b;
  logic [NA-1:0] rst_out_a;
  logic [NB-1:0] rst_out_b;

  clk_phase_rst_seq #(
    .RATIO(RA), .SYNC_PHASE(SPA), .RST_CYCLES(RCA), .N_RST(NA), .STAGGER(STA), .LOCK_FILT(8)
  ) dut_a (
    .clk_4x_s(clk_4x_s), .rst(rst), .pll_lock(pll_lock), .ext_rst_req(ext_rst_req),
    .phase(phase_a), .sync_4x(sync_a), .slow_en(slow_a), .rst_out(rst_out_a), .ready(ready_a)
  );

  clk_phase_rst_seq #(
    .RATIO(RB), .SYNC_PHASE(SPB), .RST_CYCLES(RCB), .N_RST(NB), .STAGGER(STB), .LOCK_FILT(8)
  ) dut_b (
    .clk_4x_s(clk_4x_s), .rst(rst), .pll_lock(pll_lock), .ext_rst_req(ext_rst_req),
    .phase(phase_b), .sync_4x(sync_b), .slow_en(slow_b), .rst_out(rst_out_b), .ready(ready_b)
  );

  always #5 clk_4x_s = ~clk_4x_s;

  typedef struct {
    int         edge_n;
    logic [7:0] rst_out;
    logic       ready;
  } ev_t;

  ev_t  q_a[$];
  ev_t  q_b[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, t_rst = 0;
  logic rst_seen = 1'b1;
  bit   chk_en = 1'b0;
  logic [NA:0] prev_a;
  logic [NB:0] prev_b;

  always @(posedge clk_4x_s) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    if (rst) t_rst <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_4x_s);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step();
  endtask

  // Edge at which release j happens, counted from HOLD entry at edge h, phase zeroed at edge tr.
  function automatic int rel_edge(input int h, input int tr, input int ratio, input int rc,
                                  input int st, input int j);
    int p, t1;
    p  = (h - tr) % ratio;
    t1 = h + (ratio - 1 - p);
    return t1 + (rc - 1) * ratio + 1 + j * st * ratio;
  endfunction

  task automatic push_ev(input int d, input int e, input logic [7:0] ro, input logic rdy);
    ev_t ev;
    ev.edge_n = e;
    ev.rst_out = ro;
    ev.ready = rdy;
    if (d == 0) q_a.push_back(ev);
    else q_b.push_back(ev);
  endtask

  // cutoff < 0: sequence completes; otherwise everything is forced back to reset at cutoff.
  task automatic plan(input int h, input int tr, input int cutoff);
    int e, n;
    bit any;
    logic [7:0] ones, ro;
    for (int d = 0; d < 2; d++) begin
      n    = (d == 0) ? NA : NB;
      ones = (d == 0) ? 8'h03 : 8'h07;
      any  = 1'b0;
      for (int j = 0; j < n; j++) begin
        e = (d == 0) ? rel_edge(h, tr, RA, RCA, STA, j) : rel_edge(h, tr, RB, RCB, STB, j);
        if (cutoff < 0 || e < cutoff) begin
          ro = (8'hFF << (j + 1)) & ones;
          push_ev(d, e, ro, j == n - 1);
          any = 1'b1;
        end
      end
      if (any && cutoff >= 0) push_ev(d, cutoff, ones, 1'b0);
    end
  endtask

  task automatic on_change(input int d, input logic [7:0] ro, input logic rdy);
    ev_t   ev;
    int    sz;
    string nm;
    nm = (d == 0) ? "a" : "b";
    sz = (d == 0) ? q_a.size() : q_b.size();
    checks++;
    assert (sz != 0) else begin
      errors++;
      $error("FAIL %s_unexpected_change: observed rst_out=%0h ready=%0d at edge %0d, none expected",
             nm, ro, rdy, cyc);
    end
    if (sz != 0) begin
      ev = (d == 0) ? q_a.pop_front() : q_b.pop_front();
      check({nm, "_event_edge"}, cyc, ev.edge_n);
      check({nm, "_event_rst_out"}, {24'h0, ro}, {24'h0, ev.rst_out});
      check({nm, "_event_ready"}, {31'h0, rdy}, {31'h0, ev.ready});
    end
  endtask

  always @(negedge clk_4x_s) begin
    if (!chk_en) begin
      prev_a <= {rst_out_a, ready_a};
    end else if ({rst_out_a, ready_a} !== prev_a) begin
      on_change(0, {6'h0, rst_out_a}, ready_a);
      prev_a <= {rst_out_a, ready_a};
    end
  end

  always @(negedge clk_4x_s) begin
    if (!chk_en) begin
      prev_b <= {rst_out_b, ready_b};
    end else if ({rst_out_b, ready_b} !== prev_b) begin
      on_change(1, {5'h0, rst_out_b}, ready_b);
      prev_b <= {rst_out_b, ready_b};
    end
  end

  // Phase and strobe model: phase counts edges since the last edge that sampled rst.
  always @(negedge clk_4x_s) begin
    int pa, pb;
    if (chk_en) begin
      pa = rst_seen ? 0 : (cyc - t_rst) % RA;
      pb = rst_seen ? 0 : (cyc - t_rst) % RB;
      check("a_phase", phase_a, pa);
      check("a_sync", sync_a, !rst_seen && pa == SPA);
      check("a_slow", slow_a, !rst_seen && pa == RA - 1);
      check("b_phase", phase_b, pb);
      check("b_sync", sync_b, !rst_seen && pb == SPB);
      check("b_slow", slow_b, !rst_seen && pb == RB - 1);
    end
  end

  initial begin
    int e0, g, h, q, r, tr;
    rst = 1'b1;
    repeat (3) step();
    check("rst_phase_a", phase_a, 0);
    check("rst_sync_a", sync_a, 0);
    check("rst_slow_a", slow_a, 0);
    check("rst_rst_out_a", rst_out_a, 2'b11);
    check("rst_ready_a", ready_a, 0);
    check("rst_phase_b", phase_b, 0);
    check("rst_rst_out_b", rst_out_b, 3'b111);
    check("rst_ready_b", ready_b, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    tr = cyc;
    repeat (8) step();

    // Lock rises; A is interrupted by a one-cycle lock glitch while half released.
    pll_lock = 1'b1;
    e0 = cyc;
    h  = e0 + 11;
    g  = rel_edge(h, tr, RA, RCA, STA, 0) + 3;
    plan(h, tr, g + 3);
    wait_until(g);
    pll_lock = 1'b0;
    step();
    check("a_mid_stagger_rst_out", rst_out_a, 2'b10);
    pll_lock = 1'b1;

    // Full restart, then an external request held for 20 cycles once both are running.
    h = g + 12;
    q = rel_edge(h, tr, RA, RCA, STA, NA - 1) + 5;
    plan(h, tr, q + 3);
    wait_until(q);
    check("a_ready_before_req", ready_a, 1);
    check("b_ready_before_req", ready_b, 1);
    ext_rst_req = 1'b1;
    wait_until(q + 20);
    check("a_held_in_reset", rst_out_a, 2'b11);
    ext_rst_req = 1'b0;

    // Re-sequence from the request release; a one-cycle rst lands in A's HOLD period.
    h = q + 23;
    r = h + 10;
    plan(h, tr, r + 1);
    wait_until(r);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tr = r + 1;
    h = r + 12;
    plan(h, tr, -1);
    wait_until(rel_edge(h, tr, RA, RCA, STA, NA - 1) + 6);
    check("a_final_ready", ready_a, 1);
    check("a_events_pending", q_a.size(), 0);
    check("b_events_pending", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
